draw_scheduler: RTL and testbench

Sequences one screen-refresh pass of the colour-bounce game. It shares the single rectangle-drawer port between three jobs: erasing the old ball, drawing the four platforms and drawing the new ball. After the pass it pulses a commit strobe so the game-state memory register loads the next state. It sits between the game-state memory register (upstream, supplying ball/platform/colour state) and the VGA rectangle drawer (downstream, req/ack).

---
 rtl/draw_scheduler.sv | 175 +++++++++++++++++
 tb/tb_draw_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Refresh-pass sequencer: erase old ball, 4 platforms, new ball, then a 1-cycle mem_commit; 1 rect/cycle when ack is high.
// Fields are held while draw_ack is low; define DRAW_SCHED_WDOG_EN to abort a stalled pass via wdog_err.
module draw_scheduler #(
  parameter logic [6:0] BALL_Y     = 7'd100,
  parameter logic [7:0] PLAT_PITCH = 8'd40
`ifdef DRAW_SCHED_WDOG_EN
  , parameter logic [9:0] WDOG_LIMIT = 10'd1023
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic [7:0]  prev_ball,
  input  logic [7:0]  curr_ball,
  input  logic [2:0]  color_ball,
  input  logic [11:0] color_plats,
  input  logic [27:0] position_plats,
  input  logic        draw_ack,
  output logic        draw_req,
  output logic [7:0]  draw_x,
  output logic [6:0]  draw_y,
  output logic        draw_kind,
  output logic [2:0]  draw_color,
  output logic        mem_commit,
  output logic        busy,
  output logic [7:0]  overrun_cnt
`ifdef DRAW_SCHED_WDOG_EN
  , output logic      wdog_err
`endif
);

  typedef enum logic [2:0] {IDLE, ERASE, PLAT, BALL, COMMIT} state_t;

  state_t      state;
  logic [1:0]  p;
  logic [7:0]  snap_curr;
  logic [2:0]  snap_cball;
  logic [11:0] snap_cplats;
  logic [27:0] snap_pos;
  logic        xfer;

  assign xfer = draw_req && draw_ack;

  function automatic logic [7:0] plat_x(input logic [1:0] i);
    logic [7:0] iw;
    iw = {6'b0, i};
    return iw * PLAT_PITCH;
  endfunction

  function automatic logic [6:0] plat_y(input logic [27:0] pos, input logic [1:0] i);
    return pos[7*i +: 7];
  endfunction

  function automatic logic [2:0] plat_c(input logic [11:0] col, input logic [1:0] i);
    return col[3*i +: 3];
  endfunction

`ifdef DRAW_SCHED_WDOG_EN
  logic [9:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      p           <= 2'd0;
      draw_req    <= 1'b0;
      draw_x      <= 8'd0;
      draw_y      <= 7'd0;
      draw_kind   <= 1'b0;
      draw_color  <= 3'd0;
      mem_commit  <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= 8'd0;
      snap_curr   <= 8'd0;
      snap_cball  <= 3'd0;
      snap_cplats <= 12'd0;
      snap_pos    <= 28'd0;
`ifdef DRAW_SCHED_WDOG_EN
      wd_cnt      <= 10'd0;
      wdog_err    <= 1'b0;
`endif
    end else begin
      // Any tick not consumed in IDLE, including the COMMIT cycle, is an overrun.
      if (frame_tick && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (frame_tick) begin
            snap_curr   <= curr_ball;
            snap_cball  <= color_ball;
            snap_cplats <= color_plats;
            snap_pos    <= position_plats;
            busy        <= 1'b1;
            draw_req    <= 1'b1;
            p           <= 2'd0;
            if (prev_ball != curr_ball) begin
              state      <= ERASE;
              draw_x     <= prev_ball;
              draw_y     <= BALL_Y;
              draw_kind  <= 1'b0;
              draw_color <= 3'd0;
            end else begin
              state      <= PLAT;
              draw_x     <= plat_x(2'd0);
              draw_y     <= plat_y(position_plats, 2'd0);
              draw_kind  <= 1'b1;
              draw_color <= plat_c(color_plats, 2'd0);
            end
          end
        end
        ERASE: begin
          if (xfer) begin
            state      <= PLAT;
            p          <= 2'd0;
            draw_x     <= plat_x(2'd0);
            draw_y     <= plat_y(snap_pos, 2'd0);
            draw_kind  <= 1'b1;
            draw_color <= plat_c(snap_cplats, 2'd0);
          end
        end
        PLAT: begin
          if (xfer) begin
            if (p == 2'd3) begin
              state      <= BALL;
              draw_x     <= snap_curr;
              draw_y     <= BALL_Y;
              draw_kind  <= 1'b0;
              draw_color <= snap_cball;
            end else begin
              p          <= p + 2'd1;
              draw_x     <= plat_x(p + 2'd1);
              draw_y     <= plat_y(snap_pos, p + 2'd1);
              draw_kind  <= 1'b1;
              draw_color <= plat_c(snap_cplats, p + 2'd1);
            end
          end
        end
        BALL: begin
          if (xfer) begin
            state      <= COMMIT;
            draw_req   <= 1'b0;
            mem_commit <= 1'b1;
          end
        end
        COMMIT: begin
          state      <= IDLE;
          mem_commit <= 1'b0;
          busy       <= 1'b0;
          p          <= 2'd0;
        end
        default: state <= IDLE;
      endcase

`ifdef DRAW_SCHED_WDOG_EN
      // Abort overrides the case above; the aborted pass never commits.
      if (draw_req && !draw_ack) begin
        if (wd_cnt == WDOG_LIMIT - 10'd1) begin
          wd_cnt   <= 10'd0;
          wdog_err <= 1'b1;
          draw_req <= 1'b0;
          busy     <= 1'b0;
          p        <= 2'd0;
          state    <= IDLE;
        end else begin
          wd_cnt <= wd_cnt + 10'd1;
        end
      end else begin
        wd_cnt <= 10'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: queue-based pass model checked every cycle, plus directed literal pins.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        resetn, frame_tick, draw_ack;
  logic [7:0]  prev_ball, curr_ball;
  logic [2:0]  color_ball;
  logic [11:0] color_plats;
  logic [27:0] position_plats;
  logic        draw_req, draw_kind, mem_commit, busy;
  logic [7:0]  draw_x, overrun_cnt;
  logic [6:0]  draw_y;
  logic [2:0]  draw_color;
`ifdef DRAW_SCHED_WDOG_EN
  logic        wdog_err;
`endif

  always #5 clk = ~clk;

  draw_scheduler dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .prev_ball(prev_ball), .curr_ball(curr_ball), .color_ball(color_ball),
    .color_plats(color_plats), .position_plats(position_plats),
    .draw_ack(draw_ack), .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y),
    .draw_kind(draw_kind), .draw_color(draw_color), .mem_commit(mem_commit),
    .busy(busy), .overrun_cnt(overrun_cnt)
`ifdef DRAW_SCHED_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       k;
    logic [2:0] c;
  } rect_t;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a pass is the list of rectangles computed at tick time.
  rect_t exp_q[$];
  rect_t obs_q[$];
  int    commit_edges[$];
  int    m_mode = 0;        // 0 idle, 1 drawing, 2 commit
  int    m_ovr = 0;
  bit    m_zero = 1'b1;
  bit    m_valid = 1'b0;
  int    cyc = 0;
  int    tick_edge = 0;
`ifdef DRAW_SCHED_WDOG_EN
  int    m_wait = 0;
  bit    m_wdog = 1'b0;
`endif

  function automatic void build_pass();
    rect_t r;
    exp_q.delete();
    if (prev_ball != curr_ball) begin
      r.x = prev_ball; r.y = 7'd100; r.k = 1'b0; r.c = 3'b000;
      exp_q.push_back(r);
    end
    for (int i = 0; i < 4; i++) begin
      r.x = 8'(i * 40);
      r.y = position_plats[7*i +: 7];
      r.k = 1'b1;
      r.c = color_plats[3*i +: 3];
      exp_q.push_back(r);
    end
    r.x = curr_ball; r.y = 7'd100; r.k = 1'b0; r.c = color_ball;
    exp_q.push_back(r);
  endfunction

  function automatic rect_t obs_at(input int i);
    rect_t z;
    z = '0;
    if (i < obs_q.size()) return obs_q[i];
    return z;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (resetn && draw_req && draw_ack) obs_q.push_back({draw_x, draw_y, draw_kind, draw_color});
    if (resetn && mem_commit) commit_edges.push_back(cyc);
    if (!resetn) begin
      m_mode = 0; m_ovr = 0; m_zero = 1'b1; m_valid = 1'b1;
      exp_q.delete();
`ifdef DRAW_SCHED_WDOG_EN
      m_wait = 0; m_wdog = 1'b0;
`endif
    end else begin
      if (m_mode != 0 && frame_tick && m_ovr < 255) m_ovr++;
      case (m_mode)
        0: if (frame_tick) begin
          build_pass();
          m_zero = 1'b0;
          m_mode = 1;
          tick_edge = cyc;
        end
        1: begin
          if (draw_ack) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_mode = 2;
`ifdef DRAW_SCHED_WDOG_EN
            m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait == 1023) begin
              m_mode = 0; m_wdog = 1'b1; m_wait = 0; exp_q.delete();
            end
`endif
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("draw_req", 32'(draw_req), 32'(m_mode == 1));
      check("mem_commit", 32'(mem_commit), 32'(m_mode == 2));
      check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
      if (m_mode == 1)
        check("rect_fields", 32'({draw_x, draw_y, draw_kind, draw_color}), 32'(exp_q[0]));
      else if (m_zero)
        check("fields_after_reset", 32'({draw_x, draw_y, draw_kind, draw_color}), 32'd0);
`ifdef DRAW_SCHED_WDOG_EN
      check("wdog_err", 32'(wdog_err), 32'(m_wdog));
`endif
    end
  end

  // Ack driver: 0 tied high, 1 fixed delay, 2 random (also while idle), 3 held low.
  int ack_mode = 0;
  int ack_delay = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    case (ack_mode)
      0: draw_ack = 1'b1;
      1: begin
        if (draw_req) begin
          if (wcnt == ack_delay) begin draw_ack = 1'b1; wcnt = 0; end
          else begin draw_ack = 1'b0; wcnt++; end
        end else begin
          draw_ack = 1'b0; wcnt = 0;
        end
      end
      2: draw_ack = ($urandom_range(0, 2) == 0);
      default: draw_ack = 1'b0;
    endcase
  end

  task automatic tick_once();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic set_scene(input logic [7:0] pv, input logic [7:0] cv);
    prev_ball = pv; curr_ball = cv;
    color_ball = 3'b101;
    color_plats = 12'b011_010_001_110;
    position_plats = 28'b0100011011110010101011101110;
  endtask

  rect_t r;

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; draw_ack = 1'b0;
    set_scene(8'd0, 8'd0);
    repeat (2) @(negedge clk);
    check("reset_req", 32'(draw_req), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovr", 32'(overrun_cnt), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic pass with erase, ack tied high.
    set_scene(8'd10, 8'd12);
    obs_q.delete(); commit_edges.delete();
    tick_once();
    repeat (10) @(negedge clk);
    check("t1_count", 32'(obs_q.size()), 32'd6);
    check("t1_erase", 32'(obs_at(0)), 32'({8'd10, 7'd100, 1'b0, 3'b000}));
    check("t1_plat0", 32'(obs_at(1)), 32'({8'd0, 7'd110, 1'b1, 3'b110}));
    r = obs_at(2); check("t1_plat1_x", 32'(r.x), 32'd40);
    r = obs_at(3); check("t1_plat2_x", 32'(r.x), 32'd80);
    r = obs_at(4); check("t1_plat3_x", 32'(r.x), 32'd120);
    check("t1_ball", 32'(obs_at(5)), 32'({8'd12, 7'd100, 1'b0, 3'b101}));
    check("t1_commits", 32'(commit_edges.size()), 32'd1);
    if (commit_edges.size() > 0) check("t1_commit_time", 32'(commit_edges[0] - tick_edge), 32'd7);

    // No erase when the ball did not move.
    set_scene(8'd50, 8'd50);
    obs_q.delete(); commit_edges.delete();
    tick_once();
    repeat (10) @(negedge clk);
    check("t2_count", 32'(obs_q.size()), 32'd5);
    r = obs_at(0); check("t2_first_kind", 32'(r.k), 32'd1);
    if (commit_edges.size() > 0) check("t2_commit_time", 32'(commit_edges[0] - tick_edge), 32'd6);
    else check("t2_commit_seen", 32'd0, 32'd1);

    // Ack delayed 3 cycles; upstream changes mid-pass must not leak in.
    ack_mode = 1; ack_delay = 3;
    repeat (2) @(negedge clk);
    set_scene(8'd10, 8'd12);
    obs_q.delete(); commit_edges.delete();
    tick_once();
    prev_ball = 8'd77; curr_ball = 8'd99; color_ball = 3'b010; position_plats = 28'hFFFFFFF;
    repeat (30) @(negedge clk);
    check("t3_count", 32'(obs_q.size()), 32'd6);
    r = obs_at(5); check("t3_ball_x", 32'(r.x), 32'd12);
    if (commit_edges.size() > 0) check("t3_commit_time", 32'(commit_edges[0] - tick_edge), 32'd25);
    else check("t3_commit_seen", 32'd0, 32'd1);

    // Overruns: three mid-pass ticks plus one in the COMMIT cycle.
    ack_mode = 0;
    set_scene(8'd10, 8'd12);
    repeat (2) @(negedge clk);
    tick_once();
    for (int k = 1; k <= 8; k++) begin
      frame_tick = (k == 2 || k == 3 || k == 4 || k == 7);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_overrun4", 32'(overrun_cnt), 32'd4);

    // Saturation while the drawer stalls.
    ack_mode = 3;
    tick_once();
    frame_tick = 1'b1;
    repeat (300) @(negedge clk);
    frame_tick = 1'b0;
    check("t4_overrun_sat", 32'(overrun_cnt), 32'd255);
    ack_mode = 0;
    repeat (12) @(negedge clk);

    // Reset mid-pass while drawing platform 2.
    set_scene(8'd10, 8'd12);
    commit_edges.delete();
    tick_once();
    repeat (3) @(negedge clk);
    check("t5_in_plat2_x", 32'(draw_x), 32'd80);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("t5_rst_req", 32'(draw_req), 32'd0);
    check("t5_rst_fields", 32'({draw_x, draw_y, draw_kind, draw_color}), 32'd0);
    check("t5_rst_ovr", 32'(overrun_cnt), 32'd0);
    repeat (10) @(negedge clk);
    check("t5_no_commit", 32'(commit_edges.size()), 32'd0);
    obs_q.delete();
    tick_once();
    repeat (10) @(negedge clk);
    check("t5_restart_count", 32'(obs_q.size()), 32'd6);
    r = obs_at(0); check("t5_restart_erase_x", 32'(r.x), 32'd10);

`ifdef DRAW_SCHED_WDOG_EN
    ack_mode = 3;
    commit_edges.delete();
    tick_once();
    repeat (1030) @(negedge clk);
    check("wd_err", 32'(wdog_err), 32'd1);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_no_commit", 32'(commit_edges.size()), 32'd0);
    ack_mode = 0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
`endif

    // Random traffic: random ack, random ticks, inputs churning every cycle.
    ack_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      prev_ball = 8'($urandom);
      curr_ball = ($urandom_range(0, 3) == 0) ? prev_ball : 8'($urandom);
      color_ball = 3'($urandom);
      color_plats = 12'($urandom);
      position_plats = 28'($urandom);
      frame_tick = ($urandom_range(0, 7) == 0);
      resetn = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    frame_tick = 1'b0; resetn = 1'b1; ack_mode = 0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
